// File: rtl/seq_signed_divider.sv
// Multi-cycle signed divider: 2N-bit dividend by N-bit divisor. It runs a radix-2
// restoring loop on magnitudes, then applies a sign fix-up and saturation.
module seq_signed_divider #(
  parameter int N = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2*N-1:0]   dividend,
  input  logic [N-1:0]     divisor,
  output logic             busy,
  output logic             done,
  output logic [N-1:0]     quotient,
  output logic [N-1:0]     remainder,
  output logic             ovf,
  output logic             dbz
);

  localparam int CW = $clog2(2*N+1);
  localparam logic [2*N-1:0] Q_LIM_POS = {{(N+1){1'b0}}, {(N-1){1'b1}}};
  localparam logic [2*N-1:0] Q_LIM_NEG = {{N{1'b0}}, 1'b1, {(N-1){1'b0}}};
  localparam logic [N-1:0]   Q_SAT_POS = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0]   Q_SAT_NEG = {1'b1, {(N-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

  state_t         r_state;
  logic [2*N-1:0] r_dvd;       // dividend magnitude shifts out MSB-first; quotient bits shift in
  logic [N-1:0]   r_dsr;
  logic [N:0]     r_prem;
  logic [CW-1:0]  r_cnt;
  logic           r_sign_q;
  logic           r_sign_r;
  logic           r_dbz;
  logic [N-1:0]   r_dvd_low;

  logic           r_busy;
  logic           r_done;
  logic [N-1:0]   r_quotient;
  logic [N-1:0]   r_remainder;
  logic           r_ovf;
  logic           r_dbz_out;

  logic [2*N-1:0] w_dvd_mag;
  logic [N-1:0]   w_dsr_mag;
  logic [N:0]     w_shift;
  logic [N:0]     w_sub;
  logic           w_ge;
  logic [2*N-1:0] w_qneg;
  logic [N-1:0]   w_rmag;
  logic [N-1:0]   w_rneg;
  logic           w_ovf;
  logic [N-1:0]   w_q_final;

  // Negating the most negative dividend yields 2^(2N-1), which is exact as unsigned.
  assign w_dvd_mag = dividend[2*N-1] ? -dividend : dividend;
  assign w_dsr_mag = divisor[N-1]    ? -divisor  : divisor;

  assign w_shift = {r_prem[N-1:0], r_dvd[2*N-1]};
  assign w_ge    = (w_shift >= {1'b0, r_dsr});
  assign w_sub   = w_shift - {1'b0, r_dsr};

  assign w_qneg  = -r_dvd;
  assign w_rmag  = r_prem[N-1:0];
  assign w_rneg  = -w_rmag;
  // A negative result may reach -2^(N-1); a positive one only 2^(N-1)-1.
  assign w_ovf   = r_sign_q ? (r_dvd > Q_LIM_NEG) : (r_dvd > Q_LIM_POS);

  always_comb begin
    w_q_final = r_sign_q ? w_qneg[N-1:0] : r_dvd[N-1:0];
    if (w_ovf) begin
      w_q_final = r_sign_q ? Q_SAT_NEG : Q_SAT_POS;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_dvd       <= '0;
      r_dsr       <= '0;
      r_prem      <= '0;
      r_cnt       <= '0;
      r_sign_q    <= 1'b0;
      r_sign_r    <= 1'b0;
      r_dbz       <= 1'b0;
      r_dvd_low   <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_ovf       <= 1'b0;
      r_dbz_out   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_dvd     <= w_dvd_mag;
            r_dsr     <= w_dsr_mag;
            r_sign_q  <= dividend[2*N-1] ^ divisor[N-1];
            r_sign_r  <= dividend[2*N-1];
            r_dbz     <= (divisor == '0);
            r_dvd_low <= dividend[N-1:0];
            r_prem    <= '0;
            r_cnt     <= '0;
            r_busy    <= 1'b1;
            r_state   <= S_RUN;
          end
        end
        S_RUN: begin
          r_prem <= w_ge ? w_sub : w_shift;
          r_dvd  <= {r_dvd[2*N-2:0], w_ge};
          r_cnt  <= r_cnt + CW'(1);
          if (r_cnt == CW'(2*N-1)) begin
            r_state <= S_FIX;
          end
        end
        S_FIX: begin
          if (r_dbz) begin
            r_quotient  <= '1;
            r_remainder <= r_dvd_low;
            r_ovf       <= 1'b0;
          end else begin
            r_quotient  <= w_q_final;
            r_remainder <= r_sign_r ? w_rneg : w_rmag;
            r_ovf       <= w_ovf;
          end
          r_dbz_out <= r_dbz;
          r_done    <= 1'b1;
          r_busy    <= 1'b0;
          r_state   <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign quotient  = r_quotient;
  assign remainder = r_remainder;
  assign ovf       = r_ovf;
  assign dbz       = r_dbz_out;

endmodule

// File: tb/tb_seq_signed_divider.sv
// Directed bench for seq_signed_divider (N=8): sign cases, overflow, divide by zero,
// control edges and a product/operand round trip.
module tb_seq_signed_divider;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        busy;
  logic        done;
  logic [7:0]  quotient;
  logic [7:0]  remainder;
  logic        ovf;
  logic        dbz;

  int n_cmp;
  int n_err;

  seq_signed_divider #(.N(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .ovf       (ovf),
    .dbz       (dbz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Launch one operation; optionally pulse start with other operands at run cycle pulse_at.
  task automatic run_op(input int a, input int b, input int pulse_at,
                        output int lat, output int bcnt);
    @(negedge clk);
    dividend = 16'(a);
    divisor  = 8'(b);
    start    = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    dividend = ~16'(a);
    divisor  = ~8'(b);
    lat  = 0;
    bcnt = busy ? 1 : 0;
    while (!done && lat < 40) begin
      if (lat == pulse_at) begin
        start    = 1'b1;
        dividend = 16'(-100);
        divisor  = 8'(7);
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
      if (busy) bcnt++;
    end
    start = 1'b0;
    $display("op %0d / %0d -> q=%0d r=%0d ovf=%b dbz=%b lat=%0d busy_cycles=%0d",
             a, b, int'($signed(quotient)), int'($signed(remainder)), ovf, dbz, lat, bcnt);
  endtask

  task automatic chk_res(input string tag, input int q, input int r, input int o, input int z,
                         input int lat);
    chk({tag, "_q"},   int'($signed(quotient)),  q);
    chk({tag, "_r"},   int'($signed(remainder)), r);
    chk({tag, "_ovf"}, int'(ovf), o);
    chk({tag, "_dbz"}, int'(dbz), z);
    chk({tag, "_lat"}, lat, 17);
  endtask

  initial begin
    int lat;
    int bcnt;
    int seen;
    logic signed [7:0] ra;
    logic signed [7:0] rb;
    int prod;
    int exp_a;
    int exp_b;

    n_cmp    = 0;
    n_err    = 0;
    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_q",    int'(quotient), 0);
    chk("rst_r",    int'(remainder), 0);
    chk("rst_ovf",  int'(ovf), 0);
    chk("rst_dbz",  int'(dbz), 0);
    @(negedge clk);
    rst = 1'b0;

    run_op(6, 3, -1, lat, bcnt);
    chk_res("6/3", 2, 0, 0, 0, lat);
    chk("6/3_busy_cycles", bcnt, 17);
    @(posedge clk); #1;
    chk("done_one_cycle", int'(done), 0);

    run_op(-7, 2, -1, lat, bcnt);       chk_res("-7/2", -3, -1, 0, 0, lat);
    run_op(7, -2, -1, lat, bcnt);       chk_res("7/-2", -3, 1, 0, 0, lat);
    run_op(-7, -2, -1, lat, bcnt);      chk_res("-7/-2", 3, -1, 0, 0, lat);
    run_op(128, -1, -1, lat, bcnt);     chk_res("128/-1", -128, 0, 0, 0, lat);
    run_op(-16384, -128, -1, lat, bcnt); chk_res("-16384/-128", 127, 0, 1, 0, lat);
    run_op(-32768, 1, -1, lat, bcnt);   chk_res("-32768/1", -128, 0, 1, 0, lat);
    run_op(300, 2, -1, lat, bcnt);      chk_res("300/2", 127, 0, 1, 0, lat);
    run_op(32767, -128, -1, lat, bcnt); chk_res("32767/-128", -128, 127, 1, 0, lat);
    run_op(100, 0, -1, lat, bcnt);      chk_res("100/0", -1, 100, 0, 1, lat);
    run_op(-1, 0, -1, lat, bcnt);       chk_res("-1/0", -1, -1, 0, 1, lat);
    run_op(0, 5, -1, lat, bcnt);        chk_res("0/5", 0, 0, 0, 0, lat);
    run_op(0, -5, -1, lat, bcnt);       chk_res("0/-5", 0, 0, 0, 0, lat);

    // Outputs hold after done until the next FIX edge.
    repeat (3) @(posedge clk);
    #1;
    chk("hold_q", int'($signed(quotient)), 0);

    // Start pulse at run cycle 5 with other operands must not disturb the result.
    run_op(7, -2, 4, lat, bcnt);
    chk_res("pulse_7/-2", -3, 1, 0, 0, lat);
    @(posedge clk); #1;
    chk("pulse_no_restart", int'(busy), 0);

    // Reset at run cycle 9 discards the operation.
    @(negedge clk);
    dividend = 16'(100);
    divisor  = 8'(7);
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    $display("reset mid-run -> busy=%b q=%0d r=%0d ovf=%b dbz=%b done=%b",
             busy, quotient, remainder, ovf, dbz, done);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_q",    int'(quotient), 0);
    chk("midrst_r",    int'(remainder), 0);
    chk("midrst_ovf",  int'(ovf), 0);
    chk("midrst_dbz",  int'(dbz), 0);
    seen = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    chk("midrst_no_done", seen, 0);

    run_op(6, 3, -1, lat, bcnt);
    chk_res("post_rst_6/3", 2, 0, 0, 0, lat);

    // Round trip: dividend = a*b, divisor = b, start held high across done cycles.
    @(negedge clk);
    ra = 8'($urandom);
    rb = 8'($urandom_range(1, 255));
    exp_a = int'(ra);
    exp_b = int'(rb);
    prod  = exp_a * exp_b;
    dividend = 16'(prod);
    divisor  = 8'(exp_b);
    start    = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk); #1;
      lat = 0;
      while (!done && lat < 40) begin
        @(posedge clk); #1;
        lat++;
      end
      $display("rt %0d: %0d / %0d -> q=%0d r=%0d ovf=%b dbz=%b lat=%0d",
               i, prod, exp_b, int'($signed(quotient)), int'($signed(remainder)), ovf, dbz, lat);
      chk_res("roundtrip", exp_a, 0, 0, 0, lat);
      if (i < 999) begin
        ra = 8'($urandom);
        rb = 8'($urandom_range(1, 255));
        exp_a = int'(ra);
        exp_b = int'(rb);
        prod  = exp_a * exp_b;
        dividend = 16'(prod);
        divisor  = 8'(exp_b);
      end else begin
        start = 1'b0;
      end
    end

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/seq_signed_divider.md
# seq_signed_divider

Multi-cycle signed divider that inverts the 8x8 Baugh-Wooley multiply path: takes a 2N-bit signed dividend and an N-bit signed divisor and returns an N-bit signed quotient and an N-bit signed remainder. It uses a radix-2 restoring algorithm on magnitudes, followed by a sign fix-up. The accelerator uses it to rescale products and accumulator values back to operand width. Its output is checked directly against `Wallace_BaughWooley` in round-trip tests.

## Interface
- N, default 8: operand width. Dividend is 2N bits; divisor, quotient and remainder are N bits.
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request pulse; sampled only in IDLE
- dividend  input  2N  signed dividend; sampled on the accepting edge
- divisor  input  N  signed divisor; sampled on the accepting edge
- busy  output  1  high while an operation is in flight
- done  output  1  one-cycle pulse; results are valid from this cycle on
- quotient  output  N  signed quotient, truncated toward zero, saturated on overflow
- remainder  output  N  signed remainder; its sign follows the dividend
- ovf  output  1  true quotient lies outside [-2^(N-1), 2^(N-1)-1]
- dbz  output  1  divisor was zero

## Operation
- States: IDLE, RUN, FIX.
- IDLE, start=1:
  - Capture |dividend| into a 2N-bit unsigned register. Magnitude 2^(2N-1) must be representable.
  - Capture |divisor| into an N-bit unsigned register.
  - Capture sign_q = dividend[2N-1] ^ divisor[N-1], sign_r = dividend[2N-1], and the dbz condition.
  - Clear the partial remainder and the bit counter; busy<=1; go to RUN.
- RUN: one quotient bit per cycle, MSB first, restoring:
  - Shift the partial remainder left and bring in the next dividend bit.
  - Subtract the divisor magnitude; keep the result if it is non-negative and set the quotient bit.
  - The partial remainder needs N+1 bits.
  - After 2N iterations go to FIX.
- FIX: one cycle that computes all outputs, then done<=1, busy<=0, go to IDLE.
  - Quotient Q (2N bits) = sign_q ? -qmag : qmag; remainder = sign_r ? -rmag : rmag.
  - |r| < |d| ≤ 2^(N-1), so the remainder always fits in N bits.
  - ovf=1 when Q does not fit in N signed bits. quotient then saturates to 2^(N-1)-1 if sign_q=0, or -2^(N-1) if sign_q=1. Otherwise quotient = Q[N-1:0].
  - dbz=1 overrides everything: quotient = all ones (-1), remainder = dividend[N-1:0] as captured, ovf=0.
- Zero dividend with a nonzero divisor gives quotient 0, remainder 0, no flags. There is no negative zero.
- Outputs quotient, remainder, ovf and dbz hold their values from done until the next operation's FIX edge.
- start while busy (RUN or FIX) is ignored: no queuing, no effect on the current operation.
- Inputs are don't-care except on the accepting edge.

## Timing
- Reset: state=IDLE; busy, done, quotient, remainder, ovf and dbz are all 0; counter is 0.
- rst dominates every state, including mid-RUN and FIX. The in-flight operation is discarded and no done is produced.
- Accepting edge E0 (IDLE and start=1): busy is 1 from the cycle after E0.
- RUN occupies edges E1..E2N; FIX is edge E(2N+1).
- Edge E(2N+1) sets done=1 and busy=0 together, so done is high for exactly one cycle.
- Latency: done asserts 2N+1 cycles after the accepting edge, which is 17 for N=8. Latency is fixed for all cases, including dbz and ovf.
- Back-to-back: the done cycle is in IDLE, so start=1 during done is accepted. Throughput is one operation per 2N+1 cycles.
- start held high continuously restarts an operation on every done cycle.

## Test plan
- After reset, 6 / 3 → done at +17 cycles, quotient=2, remainder=0, ovf=0, dbz=0; busy high for exactly 17 cycles.
- Sign cases:
  - -7 / 2 → quotient=-3, remainder=-1.
  - 7 / -2 → quotient=-3, remainder=1.
  - -7 / -2 → quotient=3, remainder=-1.
  - 128 / -1 → quotient=-128, ovf=0.
- Overflow:
  - -16384 / -128 → quotient=127, ovf=1.
  - -32768 / 1 → quotient=-128, ovf=1.
  - 300 / 2 → quotient=127, ovf=1, remainder=0.
- 100 / 0 → dbz=1, quotient=-1, remainder=100, ovf=0, latency still 17.
- Round trip: 1000 random signed 8-bit pairs a and b≠0. Feed prod=a*b from `Wallace_BaughWooley` as the dividend and b as the divisor → quotient=a, remainder=0, no flags. Issue the pairs back-to-back with start asserted on each done cycle.
- Control edges:
  - Pulse start at cycle 5 of a run with different operands → the original operation's result is unchanged.
  - Assert rst at cycle 9 of a run → busy=0 and all outputs 0 on the next cycle, and no done pulse.
  - A following 6 / 3 completes normally.
